// File: rtl/display_pkg.sv
// Shared types and constants for the dual seven-segment strobe controller.
package display_pkg;

    typedef enum logic [1:0] {
        BLANK_R = 2'd0,
        SHOW_R  = 2'd1,
        BLANK_L = 2'd2,
        SHOW_L  = 2'd3
    } strobe_state_t;

    localparam logic       SEL_RIGHT = 1'b0;
    localparam logic       SEL_LEFT  = 1'b1;
    localparam logic [1:0] AN_OFF    = 2'b11;
    localparam logic [1:0] AN_RIGHT  = 2'b10;
    localparam logic [1:0] AN_LEFT   = 2'b01;

    localparam int DEFAULT_HOLD_CYCLES  = 24000;
    localparam int DEFAULT_BLANK_CYCLES = 200;

endpackage

// File: rtl/display_strobe_dwell_counter.sv
// Loadable down-counter measuring how long the strobe stays in each state.
// `zero` flags the cycle on which the current dwell runs out, so the owner
// can reload in that same cycle instead of letting the count sit at 0.
module dwell_counter #(
    parameter int          W       = 8,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec_en,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // The count is on its last cycle when one (or, defensively, zero) remains.
    assign zero = (cnt_q <= W'(1));

    // Next count: load has priority, decrement never goes below zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec_en && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/display_strobe.sv
// Select/strobe controller for the multiplexed two-digit display. Cycles
// BLANK_R, SHOW_R, BLANK_L, SHOW_L; sel only changes as a blank state is
// shown, so the external mux and decoder settle while both anodes are dark.
module display_strobe
    import display_pkg::*;
#(
    parameter int HOLD_CYCLES  = DEFAULT_HOLD_CYCLES,
    parameter int BLANK_CYCLES = DEFAULT_BLANK_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    output logic       sel,
    output logic [1:0] an_n,
    output logic       frame_tick
);

    localparam int MAX_DWELL = (HOLD_CYCLES > BLANK_CYCLES) ? HOLD_CYCLES : BLANK_CYCLES;
    localparam int CNT_W     = $clog2(MAX_DWELL + 1);
    localparam bit SKIP_BLANK = (BLANK_CYCLES == 0);

    localparam strobe_state_t RST_STATE = SKIP_BLANK ? SHOW_R : BLANK_R;
    localparam logic [CNT_W-1:0] HOLD_VAL  = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] BLANK_VAL = CNT_W'(BLANK_CYCLES);
    localparam logic [CNT_W-1:0] RST_CNT   = SKIP_BLANK ? HOLD_VAL : BLANK_VAL;

    strobe_state_t    state_q, state_d;
    logic             sel_q, sel_d;
    logic [1:0]       an_n_q, an_n_d;
    logic             frame_tick_q, frame_tick_d;
    logic             load_s;
    logic [CNT_W-1:0] load_val_s;
    logic             dec_en_s;
    logic             zero_s;

    function automatic strobe_state_t next_state(input strobe_state_t s);
        case (s)
            BLANK_R: next_state = SHOW_R;
            SHOW_R:  next_state = SKIP_BLANK ? SHOW_L : BLANK_L;
            BLANK_L: next_state = SHOW_L;
            SHOW_L:  next_state = SKIP_BLANK ? SHOW_R : BLANK_R;
            default: next_state = RST_STATE;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] dwell_of(input strobe_state_t s);
        case (s)
            SHOW_R, SHOW_L: dwell_of = HOLD_VAL;
            default:        dwell_of = BLANK_VAL;
        endcase
    endfunction

    function automatic logic [1:0] anodes_of(input strobe_state_t s);
        case (s)
            SHOW_R:  anodes_of = AN_RIGHT;
            SHOW_L:  anodes_of = AN_LEFT;
            default: anodes_of = AN_OFF;
        endcase
    endfunction

    function automatic logic sel_of(input strobe_state_t s);
        case (s)
            BLANK_L, SHOW_L: sel_of = SEL_LEFT;
            default:         sel_of = SEL_RIGHT;
        endcase
    endfunction

    dwell_counter #(
        .W       (CNT_W),
        .RST_VAL (RST_CNT)
    ) u_dwell (
        .clk      (clk),
        .reset    (reset),
        .load     (load_s),
        .load_val (load_val_s),
        .dec_en   (dec_en_s),
        .zero     (zero_s)
    );

    // Sequencing: advance and reload when the dwell of the current state ends.
    always_comb begin
        state_d    = state_q;
        load_s     = 1'b0;
        load_val_s = '0;
        dec_en_s   = 1'b0;
        if (en && zero_s) begin
            state_d    = next_state(state_q);
            load_s     = 1'b1;
            load_val_s = dwell_of(state_d);
        end else if (en) begin
            dec_en_s = 1'b1;
        end else begin
            state_d = state_q;
        end
    end

    // Output decode for the cycle being consumed; paused cycles are dark.
    always_comb begin
        sel_d        = sel_q;
        an_n_d       = AN_OFF;
        frame_tick_d = 1'b0;
        if (en) begin
            sel_d        = sel_of(state_q);
            an_n_d       = anodes_of(state_q);
            frame_tick_d = (state_q == SHOW_L) && zero_s;
        end else begin
            sel_d        = sel_q;
            an_n_d       = AN_OFF;
            frame_tick_d = 1'b0;
        end
    end

    // State and output registers; reset drops any frame in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= RST_STATE;
            sel_q        <= SEL_RIGHT;
            an_n_q       <= AN_OFF;
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            an_n_q       <= an_n_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign sel        = sel_q;
    assign an_n       = an_n_q;
    assign frame_tick = frame_tick_q;

endmodule
